// File: rtl/hwgen_player.sv
// hwgen_player
// Replays hwgen records as AXI-Stream packets. Each record is one header beat
// followed by payload beats. The header holds the magic number, the original
// packet length in bytes and an inter-frame gap in clock cycles. The header is
// consumed and not forwarded. After the gap, the payload passes through with
// zero latency. The last beat is marked and its byte strobes are trimmed to
// the original length.
//
// Ports
//   clk, rst          : single rising-edge clock, synchronous active-high reset
//   en                : allows a new header to be accepted
//   s_axis_*          : hwgen record input stream (tvalid/tready/tlast/tdata/tstrb)
//   m_axis_*          : replayed packet stream (tvalid/tready/tlast/tdata/tstrb)
//   pkt_done          : one-cycle pulse after a packet completes normally
//   err_magic         : one-cycle pulse after a header with a bad magic number
//   err_len           : one-cycle pulse after any length inconsistency
//   pkt_cnt           : number of packets emitted with m_axis_tlast, wrapping
//   busy              : high whenever a record is in progress
module hwgen_player #(
  parameter logic [15:0] MAGIC      = 16'h6969,
  parameter int          DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axis_tstrb,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic                      pkt_done,
  output logic                      err_magic,
  output logic                      err_len,
  output logic [31:0]               pkt_cnt,
  output logic                      busy
);

  typedef enum logic [1:0] {HDR, GAP, DATA, DROP} state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q;
  logic [15:0] beats_q;
  logic [31:0] gap_q;
  logic [15:0] beat_cnt_q;
  logic        pkt_done_q, err_magic_q, err_len_q;
  logic [31:0] pkt_cnt_q;

  logic        done_set, magic_set, len_set, cnt_inc;
  logic        hdr_fire, s_fire, is_final;
  logic [15:0] hdr_magic, hdr_len;
  logic [31:0] hdr_ifg;
  logic [7:0]  final_strb;

  assign hdr_magic = s_axis_tdata[15:0];
  assign hdr_len   = s_axis_tdata[31:16];
  assign hdr_ifg   = s_axis_tdata[63:32];

  assign hdr_fire = (state_q == HDR) && en && s_axis_tvalid;
  assign s_fire   = s_axis_tvalid && s_axis_tready;
  // The beat being presented is number beat_cnt_q+1. It is final when that
  // number equals the beat count computed from the header.
  assign is_final = ((beat_cnt_q + 16'd1) == beats_q);
  // A length that is a multiple of 8 fills the last beat. Otherwise only the
  // low len[2:0] bytes of the last beat are valid.
  assign final_strb = (len_q[2:0] == 3'd0) ? 8'hFF : ~(8'hFF << len_q[2:0]);

  // Next-state and stream outputs. In DATA the payload is a combinational
  // pass-through. Event flags are registered, so the pulses appear the cycle
  // after the deciding beat.
  always_comb begin
    state_d       = state_q;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tstrb  = '0;
    m_axis_tlast  = 1'b0;
    done_set      = 1'b0;
    magic_set     = 1'b0;
    len_set       = 1'b0;
    cnt_inc       = 1'b0;

    case (state_q)
      HDR: begin
        s_axis_tready = en;
        if (hdr_fire) begin
          if (hdr_magic != MAGIC) begin
            magic_set = 1'b1;
            state_d   = DROP;
          end else if (hdr_len == 16'd0) begin
            len_set = 1'b1;
            state_d = DROP;
          end else if (hdr_ifg != 32'd0) begin
            state_d = GAP;
          end else begin
            state_d = DATA;
          end
        end
      end

      GAP: begin
        if (gap_q <= 32'd1) state_d = DATA;
      end

      DATA: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        if (s_axis_tvalid) begin
          m_axis_tdata = s_axis_tdata;
          if (is_final) begin
            m_axis_tlast = 1'b1;
            m_axis_tstrb = final_strb;
          end else if (s_axis_tlast) begin
            m_axis_tlast = 1'b1;
            m_axis_tstrb = s_axis_tstrb;
          end else begin
            m_axis_tstrb = 8'hFF;
          end
        end
        if (s_axis_tvalid && m_axis_tready) begin
          if (is_final) begin
            cnt_inc = 1'b1;
            if (s_axis_tlast) begin
              done_set = 1'b1;
              state_d  = HDR;
            end else begin
              // The source has more beats than the header promised. Drop them.
              len_set = 1'b1;
              state_d = DROP;
            end
          end else if (s_axis_tlast) begin
            cnt_inc = 1'b1;
            len_set = 1'b1;
            state_d = HDR;
          end
        end
      end

      DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_d = HDR;
      end

      default: state_d = HDR;
    endcase

    if (rst) begin
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tstrb  = '0;
      m_axis_tlast  = 1'b0;
    end
  end

  // State register, header latches, gap and beat counters, and event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HDR;
      len_q       <= '0;
      beats_q     <= '0;
      gap_q       <= '0;
      beat_cnt_q  <= '0;
      pkt_done_q  <= 1'b0;
      err_magic_q <= 1'b0;
      err_len_q   <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      pkt_done_q  <= done_set;
      err_magic_q <= magic_set;
      err_len_q   <= len_set;
      if (cnt_inc) pkt_cnt_q <= pkt_cnt_q + 32'd1;

      if (hdr_fire) begin
        len_q      <= hdr_len;
        beats_q    <= 16'(({1'b0, hdr_len} + 17'd7) >> 3);
        gap_q      <= hdr_ifg;
        beat_cnt_q <= '0;
      end

      if (state_q == GAP) gap_q <= gap_q - 32'd1;

      if ((state_q == DATA) && s_fire) beat_cnt_q <= beat_cnt_q + 16'd1;
    end
  end

  assign pkt_done  = pkt_done_q;
  assign err_magic = err_magic_q;
  assign err_len   = err_len_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign busy      = (state_q != HDR);

endmodule

// File: tb/tb_hwgen_player.sv
// tb_hwgen_player
// Self-checking bench for hwgen_player. The bench holds a record-level model
// of the player. For each record it works out which output beats are expected,
// with their strobes and last flags, and which event pulses should occur. It
// does this from the record's magic number, length and beat count. A monitor
// compares every transferred output beat against that queue. It also counts
// the event pulses.
module tb_hwgen_player;

  localparam logic [15:0] MAGIC = 16'h6969;

  logic        clk = 1'b0;
  logic        rst, en;
  logic        s_tvalid, s_tready, s_tlast;
  logic [63:0] s_tdata;
  logic [7:0]  s_tstrb;
  logic        m_tvalid, m_tready, m_tlast;
  logic [63:0] m_tdata;
  logic [7:0]  m_tstrb;
  logic        pkt_done, err_magic, err_len, busy;
  logic [31:0] pkt_cnt;

  always #5 clk = ~clk;

  hwgen_player #(.MAGIC(MAGIC), .DATA_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .en(en),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb),
    .pkt_done(pkt_done), .err_magic(err_magic), .err_len(err_len),
    .pkt_cnt(pkt_cnt), .busy(busy)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_beat;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          done_seen = 0, magic_seen = 0, len_seen = 0;
  int          exp_done = 0, exp_magic = 0, exp_len = 0;
  logic [31:0] exp_pkt_cnt = 32'd0;
  int          first_valid_cyc = -1;
  logic        backpressure = 1'b0;
  logic        rand_idle = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Output-side ready, optionally randomised, changed just after each edge.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = backpressure ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: counts pulses and checks every output beat and the idle bus.
  always @(negedge clk) begin
    if (pkt_done)  done_seen++;
    if (err_magic) magic_seen++;
    if (err_len)   len_seen++;
    if (m_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_beat", {m_tdata[62:0], 1'b1}, 64'd0);
      end else begin
        mon_beat = exp_q.pop_front();
        checkOutput("beat_data", m_tdata, mon_beat.data);
        checkOutput("beat_strb", 64'(m_tstrb), 64'(mon_beat.strb));
        checkOutput("beat_last", 64'(m_tlast), 64'(mon_beat.last));
      end
    end else if (!m_tvalid) begin
      checkOutput("idle_bus_zero", m_tdata | 64'(m_tstrb) | 64'(m_tlast), 64'd0);
    end
  end

  // Present one input beat and hold it until it is accepted, or until the
  // wait runs out. Returns the cycle in which the handshake happened.
  task automatic pushBeat(input logic [63:0] data, input logic [7:0] strb,
                          input logic last, output int acc_cyc);
    logic ready;
    s_tvalid = 1'b1;
    s_tdata  = data;
    s_tstrb  = strb;
    s_tlast  = last;
    acc_cyc  = -1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      ready = s_tready;
      if (ready) acc_cyc = cyc;
      @(posedge clk);
      #1;
      if (ready) break;
    end
    if (acc_cyc < 0) checkOutput("accept_timeout", 64'd0, 64'd1);
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tstrb  = '0;
    s_tlast  = 1'b0;
    if (rand_idle && $urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settleAndCheck();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("exp_queue_empty", 64'(exp_q.size()), 64'd0);
    checkOutput("pkt_done_count", 64'(done_seen), 64'(exp_done));
    checkOutput("err_magic_count", 64'(magic_seen), 64'(exp_magic));
    checkOutput("err_len_count", 64'(len_seen), 64'(exp_len));
    checkOutput("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt_cnt));
    checkOutput("busy_idle", 64'(busy), 64'd0);
  endtask

  // Send one record of n_beats payload beats. tlast is on the last payload
  // beat. Only the first 'cut' beats are sent, so a record can be abandoned
  // partway. The model predicts the output beats and the event counts.
  task automatic applyStimulus(input logic [15:0] magic, input logic [15:0] len,
                               input logic [31:0] ifg, input int n_beats,
                               input int cut, input bit exact_gap, input bit drop_en);
    logic [63:0] data [64];
    logic [7:0]  strb [64];
    logic [7:0]  tail;
    int          beats, n_out, hdr_cyc, acc;
    bit          has_out;
    beat_t       b;

    for (int i = 0; i < n_beats; i++) begin
      data[i] = {$urandom, $urandom};
      strb[i] = 8'($urandom);
    end

    beats   = (int'(len) + 7) / 8;
    tail    = (int'(len) % 8 == 0) ? 8'hFF : 8'((1 << (int'(len) % 8)) - 1);
    has_out = (magic == MAGIC) && (len != 16'd0);
    if (has_out) begin
      n_out = (n_beats < beats) ? n_beats : beats;
      for (int i = 0; i < n_out; i++) begin
        b.data = data[i];
        b.last = (i == n_out - 1);
        if (!b.last)               b.strb = 8'hFF;
        else if (n_beats < beats)  b.strb = strb[i];
        else                       b.strb = tail;
        exp_q.push_back(b);
      end
    end
    if (cut == n_beats) begin
      if (magic != MAGIC)        exp_magic++;
      else if (len == 16'd0)     exp_len++;
      else begin
        if (n_beats == beats) exp_done++;
        else                  exp_len++;
        exp_pkt_cnt = exp_pkt_cnt + 32'd1;
      end
    end

    first_valid_cyc = -1;
    pushBeat({ifg, len, magic}, 8'hFF, 1'b0, hdr_cyc);
    if (drop_en) en = 1'b0;
    for (int i = 0; i < cut; i++) pushBeat(data[i], strb[i], (i == n_beats - 1), acc);
    en = 1'b1;

    if (cut == n_beats) begin
      if (has_out) begin
        if (exact_gap)
          checkOutput("gap_exact", 64'(first_valid_cyc), 64'(hdr_cyc + 1 + int'(ifg)));
        else
          checkOutput("gap_min", 64'(first_valid_cyc >= hdr_cyc + 1 + int'(ifg)), 64'd1);
      end
      settleAndCheck();
    end
  endtask

  initial begin
    logic [15:0] r_magic, r_len;
    int          r_beats, r_n;

    rst      = 1'b1;
    en       = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    s_tstrb  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_s_tready", 64'(s_tready), 64'd0);
    checkOutput("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_pkt_cnt", 64'(pkt_cnt), 64'd0);
    checkOutput("reset_pulses", 64'({pkt_done, err_magic, err_len}), 64'd0);

    // en low blocks header acceptance in HDR
    en = 1'b0;
    @(negedge clk);
    checkOutput("en_low_tready", 64'(s_tready), 64'd0);
    @(posedge clk);
    #1;
    en = 1'b1;

    // Directed records
    applyStimulus(MAGIC, 16'd16, 32'd0, 2, 2, 1'b1, 1'b0);   // ifg 0, exact fit
    applyStimulus(MAGIC, 16'd13, 32'd10, 2, 2, 1'b1, 1'b1);  // ifg 10, strb 1F, en dropped
    applyStimulus(16'h1234, 16'd16, 32'd0, 3, 3, 1'b0, 1'b0); // bad magic
    applyStimulus(MAGIC, 16'd24, 32'd0, 2, 2, 1'b1, 1'b0);   // early tlast
    applyStimulus(MAGIC, 16'd8, 32'd0, 1, 1, 1'b1, 1'b0);    // next header parsed
    applyStimulus(MAGIC, 16'd8, 32'd0, 3, 3, 1'b1, 1'b0);    // late tlast
    applyStimulus(MAGIC, 16'd20, 32'd2, 3, 3, 1'b1, 1'b0);   // plays after drop
    applyStimulus(MAGIC, 16'd0, 32'd0, 2, 2, 1'b0, 1'b0);    // zero length

    // Randomised records with backpressure and idle input cycles
    backpressure = 1'b1;
    rand_idle    = 1'b1;
    for (int k = 0; k < 30; k++) begin
      r_len   = 16'($urandom_range(1, 160));
      r_beats = (int'(r_len) + 7) / 8;
      r_n     = ($urandom_range(0, 4) == 0) ? $urandom_range(1, r_beats + 3) : r_beats;
      r_magic = ($urandom_range(0, 7) == 0) ? (MAGIC ^ 16'($urandom_range(1, 65535))) : MAGIC;
      applyStimulus(r_magic, r_len, 32'($urandom_range(0, 4)), r_n, r_n, 1'b0, 1'b0);
    end

    // Reset in the middle of a record's payload
    applyStimulus(MAGIC, 16'd80, 32'd0, 10, 4, 1'b0, 1'b0);
    checkOutput("pre_reset_remaining", 64'(exp_q.size()), 64'd6);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_pkt_cnt = 32'd0;
    checkOutput("post_reset_busy", 64'(busy), 64'd0);
    checkOutput("post_reset_pkt_cnt", 64'(pkt_cnt), 64'd0);
    applyStimulus(MAGIC, 16'd27, 32'd1, 4, 4, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
